// File: rtl/uart_tx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// uart_tx_cfg : UART transmitter, configurable data/parity/stop framing
// Rev 1.0
// ==========================================================================
module uart_tx_cfg #(
   parameter int DATA_BITS  = 8,
   parameter int SB_TICKS   = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_reset,
   input  logic                 i_bd,
   input  logic                 i_Tx_Start,
   input  logic [DATA_BITS-1:0] i_Tx_Byte,
   output logic                 o_Tx_Serial,
   output logic                 o_Tx_Active,
   output logic                 o_Tx_Done
);

   localparam int TW = (SB_TICKS > 1) ? $clog2(SB_TICKS) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TW-1:0] c_TICK_LAST = TW'(SB_TICKS - 1);
   localparam logic [BW-1:0] c_BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic          c_STOP_LAST = (STOP_BITS == 2);
   localparam logic          c_PAR_ODD   = (PARITY_ODD != 0);
   localparam logic          c_PAR_EN    = (PARITY_EN != 0);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_START  = 3'd1;
   localparam logic [2:0] c_DATA   = 3'd2;
   localparam logic [2:0] c_PARITY = 3'd3;
   localparam logic [2:0] c_STOP   = 3'd4;

   logic [2:0]           state_q, state_d;
   logic [TW-1:0]        tick_q, tick_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic                 stop_q, stop_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 active_q, active_d;
   logic                 done_q, done_d;
   logic                 w_bit_end;

   assign w_bit_end = i_bd && (tick_q == c_TICK_LAST);

   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      bit_d    = bit_q;
      stop_d   = stop_q;
      shift_d  = shift_q;
      par_d    = par_q;
      active_d = active_q;
      done_d   = 1'b0;

      // The tick counter only runs inside a frame; the acceptance tick is not counted.
      if (state_q != c_IDLE && i_bd) begin
         tick_d = w_bit_end ? '0 : tick_q + 1'b1;
      end

      case (state_q)
         c_IDLE: begin
            if (i_Tx_Start) begin
               state_d  = c_START;
               shift_d  = i_Tx_Byte;
               par_d    = (^i_Tx_Byte) ^ c_PAR_ODD;
               tick_d   = '0;
               bit_d    = '0;
               stop_d   = 1'b0;
               active_d = 1'b1;
            end
         end
         c_START: begin
            if (w_bit_end) begin
               state_d = c_DATA;
               bit_d   = '0;
            end
         end
         c_DATA: begin
            if (w_bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == c_BIT_LAST) begin
                  state_d = c_PAR_EN ? c_PARITY : c_STOP;
                  stop_d  = 1'b0;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         c_PARITY: begin
            if (w_bit_end) begin
               state_d = c_STOP;
               stop_d  = 1'b0;
            end
         end
         c_STOP: begin
            if (w_bit_end) begin
               if (stop_q == c_STOP_LAST) begin
                  state_d  = c_IDLE;
                  active_d = 1'b0;
                  done_d   = 1'b1;
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end
         end
         default: begin
            state_d  = c_IDLE;
            active_d = 1'b0;
         end
      endcase
   end

   // Line level is decoded from the next state so the pin itself is a flop.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         c_START:  tx_d = 1'b0;
         c_DATA:   tx_d = shift_d[0];
         c_PARITY: tx_d = par_q;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q  <= c_IDLE;
         tick_q   <= '0;
         bit_q    <= '0;
         stop_q   <= 1'b0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         tx_q     <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         bit_q    <= bit_d;
         stop_q   <= stop_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         tx_q     <= tx_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   assign o_Tx_Serial = tx_q;
   assign o_Tx_Active = active_q;
   assign o_Tx_Done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// tb_uart_tx_cfg : directed bench for uart_tx_cfg across four framings
// Rev 1.0
// ==========================================================================
module tb_uart_tx_cfg;

   logic       clk;
   logic       rst_n;
   logic       bd;
   logic       i_start;
   logic [8:0] i_byte;
   int         sel;

   int n_vec;
   int n_miss;

   logic s0, a0, d0, s1, a1, d1, s2, a2, d2, s3, a3, d3;
   logic obs_ser, obs_act, obs_done;

   // sel 0: 8N1, 1: 8E1, 2: 8O1, 3: 5N2
   uart_tx_cfg u_dut_8n1 (
      .i_Clock(clk), .i_reset(rst_n), .i_bd(bd),
      .i_Tx_Start(i_start && sel == 0), .i_Tx_Byte(i_byte[7:0]),
      .o_Tx_Serial(s0), .o_Tx_Active(a0), .o_Tx_Done(d0));

   uart_tx_cfg #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut_8e1 (
      .i_Clock(clk), .i_reset(rst_n), .i_bd(bd),
      .i_Tx_Start(i_start && sel == 1), .i_Tx_Byte(i_byte[7:0]),
      .o_Tx_Serial(s1), .o_Tx_Active(a1), .o_Tx_Done(d1));

   uart_tx_cfg #(.PARITY_EN(1), .PARITY_ODD(1)) u_dut_8o1 (
      .i_Clock(clk), .i_reset(rst_n), .i_bd(bd),
      .i_Tx_Start(i_start && sel == 2), .i_Tx_Byte(i_byte[7:0]),
      .o_Tx_Serial(s2), .o_Tx_Active(a2), .o_Tx_Done(d2));

   uart_tx_cfg #(.DATA_BITS(5), .STOP_BITS(2)) u_dut_5n2 (
      .i_Clock(clk), .i_reset(rst_n), .i_bd(bd),
      .i_Tx_Start(i_start && sel == 3), .i_Tx_Byte(i_byte[4:0]),
      .o_Tx_Serial(s3), .o_Tx_Active(a3), .o_Tx_Done(d3));

   always_comb begin
      obs_ser  = s0;
      obs_act  = a0;
      obs_done = d0;
      case (sel)
         1: begin obs_ser = s1; obs_act = a1; obs_done = d1; end
         2: begin obs_ser = s2; obs_act = a2; obs_done = d2; end
         3: begin obs_ser = s3; obs_act = a3; obs_done = d3; end
         default: ;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sends one frame on instance s and checks it cycle by cycle against a tick model.
   // bits[k] is the k-th line bit after acceptance; all frames use 16 ticks per bit.
   task automatic run_frame(input string tag, input int s, input logic [8:0] data,
                            input int nbits, input logic [15:0] bits, input int div,
                            input int pstart, input int plen, input int exp_cyc,
                            input bit busy_poke, input bit chain_in, input bit chain_out,
                            input logic [8:0] next_data);
      int c, ticks, k, b, ctl_bad;
      int err[16];
      bit seen;
      sel = s;
      if (!chain_in) begin
         i_start = 1'b1;
         i_byte  = data;
      end
      bd = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      i_byte  = ~data;
      c = 0; ticks = 0; k = 0; ctl_bad = 0; seen = 1'b0;
      foreach (err[i]) err[i] = 0;
      while (c <= exp_cyc + 64) begin
         if (obs_done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         b = ticks / 16;
         if (b < nbits && b < 16 && obs_ser !== bits[b]) err[b]++;
         if (obs_act !== 1'b1) ctl_bad++;
         if (c >= pstart && c < pstart + plen) begin
            bd = 1'b0;
         end else begin
            bd = ((k % div) == div - 1);
            k++;
         end
         if (bd) ticks++;
         if (busy_poke) begin
            if (c == 50) begin
               i_start = 1'b1;
               i_byte  = 9'h1FF;
            end else if (c == 51) begin
               i_start = 1'b0;
               i_byte  = ~data;
            end
         end
         @(negedge clk);
         c++;
      end
      chk({tag, " done seen"}, 32'(seen), 32'd1);
      chk({tag, " frame cycles"}, 32'(c), 32'(exp_cyc));
      chk({tag, " end ser/act"}, {30'd0, obs_ser, obs_act}, 32'b10);
      chk({tag, " active/done in frame"}, 32'(ctl_bad), 32'd0);
      for (int i = 0; i < nbits; i++) begin
         chk($sformatf("%s bit%0d bad cycles", tag, i), 32'(err[i]), 32'd0);
      end
      if (chain_out) begin
         i_start = 1'b1;
         i_byte  = next_data;
      end
   endtask

   initial begin
      int bad;
      n_vec   = 0;
      n_miss  = 0;
      sel     = 0;
      bd      = 1'b0;
      i_start = 1'b0;
      i_byte  = 9'h000;
      rst_n   = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset outputs", {20'd0, s0, a0, d0, s1, a1, d1, s2, a2, d2, s3, a3, d3},
          {20'd0, 12'b100_100_100_100});
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle after reset", {29'd0, s0, a0, d0}, 32'b100);

      // 8N1, 0x55, i_bd always high
      run_frame("8N1 55", 0, 9'h055, 10, {6'd0, 1'b1, 8'h55, 1'b0}, 1, 0, 0, 160, 0, 0, 0, 9'h0);
      repeat (3) @(negedge clk);

      // even / odd parity
      run_frame("8E1 07", 1, 9'h007, 11, {5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 1, 0, 0, 176, 0, 0, 0, 9'h0);
      repeat (2) @(negedge clk);
      run_frame("8E1 03", 1, 9'h003, 11, {5'd0, 1'b1, 1'b0, 8'h03, 1'b0}, 1, 0, 0, 176, 0, 0, 0, 9'h0);
      repeat (2) @(negedge clk);
      run_frame("8O1 07", 2, 9'h007, 11, {5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 1, 0, 0, 176, 0, 0, 0, 9'h0);
      repeat (2) @(negedge clk);
      run_frame("8O1 03", 2, 9'h003, 11, {5'd0, 1'b1, 1'b1, 8'h03, 1'b0}, 1, 0, 0, 176, 0, 0, 0, 9'h0);
      repeat (2) @(negedge clk);

      // 5N2, one tick in four; the tick coinciding with acceptance is not counted
      run_frame("5N2 1A", 3, 9'h01A, 8, {8'd0, 2'b11, 5'h1A, 1'b0}, 4, 0, 0, 512, 0, 0, 0, 9'h0);
      repeat (2) @(negedge clk);

      // busy rejection, then back-to-back start in the done cycle
      run_frame("8N1 A5 busy", 0, 9'h0A5, 10, {6'd0, 1'b1, 8'hA5, 1'b0}, 1, 0, 0, 160, 1, 0, 1, 9'h03C);
      run_frame("8N1 3C b2b", 0, 9'h03C, 10, {6'd0, 1'b1, 8'h3C, 1'b0}, 1, 0, 0, 160, 0, 1, 0, 9'h0);
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if ({s0, a0, d0} !== 3'b100) bad++;
      end
      chk("no queued frame after b2b", 32'(bad), 32'd0);

      // async reset mid-frame during data bit 3 of 0x00
      sel = 0;
      bd = 1'b1;
      i_start = 1'b1;
      i_byte  = 9'h000;
      @(negedge clk);
      i_start = 1'b0;
      repeat (70) @(negedge clk);
      chk("pre-reset line low", {29'd0, s0, a0, d0}, 32'b010);
      #2 rst_n = 1'b0;
      #1 chk("async reset immediate", {29'd0, s0, a0, d0}, 32'b100);
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if ({s0, a0, d0} !== 3'b100) bad++;
      end
      chk("held in reset", 32'(bad), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      run_frame("8N1 81 after reset", 0, 9'h081, 10, {6'd0, 1'b1, 8'h81, 1'b0}, 1, 0, 0, 160, 0, 0, 0, 9'h0);
      repeat (2) @(negedge clk);

      // i_bd frozen for 1000 cycles inside data bit 2
      run_frame("8N1 C3 freeze", 0, 9'h0C3, 10, {6'd0, 1'b1, 8'hC3, 1'b0}, 1, 60, 1000, 1160, 0, 0, 0, 9'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter in the TP2-UART datapath. It serialises one word per frame, LSB first, with configurable data width, optional even/odd parity and 1 or 2 stop bits. Bit timing uses the shared oversampling baud-tick generator (i_bd): each bit lasts SB_TICKS ticks. The block sits between the ALU/interface FSM and the serial pin.

Parameters:
DATA_BITS, 8, data bits per frame (5..9).
SB_TICKS, 16, i_bd ticks per bit (oversampling factor, >=2).
PARITY_EN, 0, 1 = insert parity bit after data.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0).
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
i_Clock  input  1  system clock; all state on rising edge.
i_reset  input  1  asynchronous, active-low reset (0 = reset).
i_bd  input  1  one-cycle baud tick from the baud generator, SB_TICKS per bit period.
i_Tx_Start  input  1  request to send; sampled only in IDLE.
i_Tx_Byte  input  DATA_BITS  word to send; captured in the cycle the start is accepted.
o_Tx_Serial  output  1  serial line, registered, idle high.
o_Tx_Active  output  1  high from start acceptance until frame end.
o_Tx_Done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (i_reset=0, async): state IDLE, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, tick/bit counters 0, shift register 0. Reset mid-frame aborts the frame immediately. The line returns high with no glitch low.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: o_Tx_Serial=1. When i_Tx_Start=1:
  - capture i_Tx_Byte into the shift register and compute parity (XOR of the data, inverted if PARITY_ODD);
  - clear the tick counter and go to START.
  - On the next edge o_Tx_Serial=0 and o_Tx_Active=1.
- Tick counter: increments only on cycles with i_bd=1. A bit ends on the i_bd cycle where the counter equals SB_TICKS-1; the counter then wraps to 0. Cycles with i_bd=0 hold all state.
- START: drive 0 for SB_TICKS ticks, then go to DATA with bit index 0.
- DATA: drive shift[0]; at bit end, shift right and increment the index. After bit DATA_BITS-1, go to PARITY if PARITY_EN, otherwise go to STOP.
- PARITY: drive the parity bit for SB_TICKS ticks, then go to STOP.
- STOP: drive 1 for STOP_BITS*SB_TICKS ticks (stop-bit counter 0..STOP_BITS-1).
  - At the end of the last stop bit, go to IDLE.
  - In that same edge, o_Tx_Done=1 for exactly one cycle and o_Tx_Active=0.
- Frame length is exactly (1+DATA_BITS+PARITY_EN+STOP_BITS)*SB_TICKS ticks, measured from start acceptance to the o_Tx_Done edge.
- Back-to-back: i_Tx_Start=1 in the cycle o_Tx_Done=1 (state IDLE) is accepted. The next start bit follows with zero idle gap.
- i_Tx_Start while o_Tx_Active=1 is ignored: no queueing, no effect on the current frame. Changes on i_Tx_Byte after capture have no effect.
- i_bd coinciding with start acceptance is not counted toward the start bit; counting begins the following cycle.
- The output comes straight from registers: no combinational path from inputs to o_Tx_Serial.

Test Plan:
- 8N1 (defaults), i_bd held 1, send 0x55 -> line reads 0,1,0,1,0,1,0,1,0,1, each bit 16 cycles wide; o_Tx_Done pulses exactly 160 cycles after acceptance; o_Tx_Active high for exactly those 160 cycles.
- PARITY_EN=1, PARITY_ODD=0: send 0x07 -> parity bit 1. Send 0x03 -> parity bit 0. Repeat with PARITY_ODD=1 -> bits inverted (0, 1); frame 176 cycles.
- DATA_BITS=5, STOP_BITS=2, i_bd one cycle in every 4: send 0x1A -> 0,0,1,0,1,1,1,1; each bit 64 cycles; done at 512 cycles.
- Busy rejection and back-to-back: start 0xA5, pulse i_Tx_Start with 0xFF mid-frame -> 0xA5 frame unaltered, 0xFF never sent. Then assert start with 0x3C in the o_Tx_Done cycle -> 0x3C start bit begins on the next edge with no idle gap.
- Async reset: pull i_reset low between clock edges during bit 3 of 0x00 -> o_Tx_Serial=1 and o_Tx_Active=0 immediately, o_Tx_Done stays 0. Release, then start 0x81 -> a clean full frame.
- i_bd held 0 for 1000 cycles mid-DATA -> all outputs frozen. Resume ticks -> the frame completes with correct bit widths.
